// File: rtl/spi_master_ctrl_pkg.sv
// Shared state encoding, frame geometry and frame builder for the SPI memory master.
package spi_master_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GUARD = 3'd4
   } state_t;

   localparam int   FRAME_BITS = 16;
   localparam int   ADDR_W     = 7;
   localparam int   DATA_W     = 8;
   localparam logic RW_READ    = 1'b1;

   // Reads put an all-zero data byte on the wire.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic              rw,
                                                        input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] wdata);
      logic [DATA_W-1:0] data;
      data = (rw == RW_READ) ? '0 : wdata;
      return {addr, rw, data};
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response bus of the SPI memory master.
interface spi_master_ctrl_if;
   import spi_master_ctrl_pkg::*;

   logic              req;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rdata;

   modport master (output req, rw, addr, wdata, input  busy, done, rdata);
   modport slave  (input  req, rw, addr, wdata, output busy, done, rdata);

endinterface

// File: rtl/spi_master_ctrl_clk_gen.sv
// Half-period timer: phase-end strobes for every state, sclk toggling only while shifting.
module spi_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,         // count phases (any non-idle state)
   input  logic toggle_en,  // let sclk toggle at phase ends
   output logic sclk,
   output logic tick,       // last cycle of a CLK_DIV phase
   output logic pre_tick,   // one cycle before tick
   output logic rise,       // sclk goes high at the coming edge
   output logic fall        // sclk goes low at the coming edge
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] PRE  = 8'(CLK_DIV - 2);

   logic [7:0] cnt;

   assign tick     = en && (cnt == LAST);
   assign pre_tick = en && (cnt == PRE);
   assign rise     = tick && toggle_en && !sclk;
   assign fall     = tick && toggle_en &&  sclk;

   // NOTE: registered state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else begin
         if (!en || tick) cnt <= '0;
         else             cnt <= cnt + 8'd1;

         if (!toggle_en) sclk <= 1'b0;
         else if (tick)  sclk <= !sclk;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master issuing one 16-bit {addr, rw, data} frame per accepted host request.
module spi_master_ctrl
   import spi_master_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   spi_master_ctrl_if.slave bus,
   output logic             cs_pin,
   output logic             sclk_pin,
   output logic             mosi_pin,
   input  logic             miso_pin
);

   state_t                state, state_nxt;
   logic                  tick, pre_tick, rise, fall;
   logic                  cg_en, cg_toggle;
   logic [FRAME_BITS-1:0] tx_shreg;
   logic [DATA_W-1:0]     rx_shreg;
   logic [3:0]            bit_cnt;
   logic                  rw_q;
   logic                  accept, last_bit, guard_end;

   assign accept    = (state == IDLE) && bus.req;
   assign last_bit  = (bit_cnt == 4'(FRAME_BITS - 1));
   assign cg_en     = (state != IDLE);
   assign cg_toggle = (state == SHIFT);
   // done is registered one cycle early so it lands in the last GUARD cycle.
   assign guard_end = (state == GUARD) && pre_tick;
   assign bus.busy  = (state != IDLE) && !bus.done;

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (cg_en),
      .toggle_en (cg_toggle),
      .sclk      (sclk_pin),
      .tick      (tick),
      .pre_tick  (pre_tick),
      .rise      (rise),
      .fall      (fall)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_nxt = state;
      cs_pin    = 1'b1;
      mosi_pin  = 1'b0;
      unique case (state)
         IDLE:  if (accept) state_nxt = SETUP;
         SETUP: begin
            cs_pin   = 1'b0;
            mosi_pin = tx_shreg[FRAME_BITS-1];
            if (tick) state_nxt = SHIFT;
         end
         SHIFT: begin
            cs_pin   = 1'b0;
            mosi_pin = tx_shreg[FRAME_BITS-1];
            if (fall && last_bit) state_nxt = HOLD;
         end
         HOLD: begin
            cs_pin = 1'b0;
            if (tick) state_nxt = GUARD;
         end
         GUARD:   if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shift registers are plain flops, so they share the async reset with the FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_shreg  <= '0;
         rx_shreg  <= '0;
         bit_cnt   <= '0;
         rw_q      <= 1'b0;
         bus.done  <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.done <= guard_end;
         if (accept) begin
            tx_shreg <= build_frame(bus.rw, bus.addr, bus.wdata);
            rx_shreg <= '0;
            bit_cnt  <= '0;
            rw_q     <= bus.rw;
         end else if (fall) begin
            tx_shreg <= {tx_shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 4'd1;
         end
         // Only the data byte (bits 7..0 of the frame) carries read data back.
         if (rise && (rw_q == RW_READ) && (bit_cnt >= 4'(FRAME_BITS - DATA_W)))
            rx_shreg <= {rx_shreg[DATA_W-2:0], miso_pin};
         if (guard_end && (rw_q == RW_READ))
            bus.rdata <= rx_shreg;
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised self-checking bench for spi_master_ctrl with a behavioural SPI memory model.
module tb_spi_master_ctrl;

   localparam int         D1    = 4;
   localparam int         D2    = 2;
   localparam int         TCLK  = 10;
   localparam logic [7:0] RESP2 = 8'hC5;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #(TCLK/2) clk = ~clk;

   spi_master_ctrl_if bus1 ();
   spi_master_ctrl_if bus2 ();

   logic cs1, sclk1, mosi1;
   logic miso1 = 1'b0;
   logic cs2, sclk2, mosi2;
   logic miso2 = 1'b0;

   spi_master_ctrl #(.CLK_DIV(D1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1),
      .cs_pin(cs1), .sclk_pin(sclk1), .mosi_pin(mosi1), .miso_pin(miso1)
   );

   spi_master_ctrl #(.CLK_DIV(D2)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2),
      .cs_pin(cs2), .sclk_pin(sclk2), .mosi_pin(mosi2), .miso_pin(miso2)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state: memory contents and the rdata each host should currently see.
   logic [7:0] mem     [128];
   logic [7:0] ref_mem [128];
   logic [7:0] last_rdata1 = 8'h00;
   logic [7:0] last_rdata2 = 8'h00;

   int done_cnt1 = 0;
   int done_cnt2 = 0;
   always @(negedge clk) begin
      if (bus1.done === 1'b1) done_cnt1++;
      if (bus2.done === 1'b1) done_cnt2++;
   end

   // SPI memory behind DUT1: captures mosi on sclk rises, answers reads from mem.
   logic [15:0] cap1 = '0;
   int          rises1 = 0, bad_per1 = 0, stray1 = 0;
   time         last_rise1 = 0;
   logic [6:0]  cur_addr1 = '0;
   logic [7:0]  byte1;
   logic        cs1_q = 1'b1;
   always @(posedge sclk1 or cs1) begin
      if (cs1 !== cs1_q) begin
         if (cs1 === 1'b1 && rises1 == 16 && cap1[8] == 1'b0) mem[cap1[15:9]] = cap1[7:0];
         if (cs1 === 1'b0) begin
            rises1 = 0;
            cap1   = '0;
            miso1  = 1'b0;
         end
         cs1_q = cs1;
      end else if (sclk1 === 1'b1) begin
         if (cs1 !== 1'b0) stray1++;
         if (rises1 > 0 && ($time - last_rise1) != 2*D1*TCLK) bad_per1++;
         last_rise1 = $time;
         cap1 = {cap1[14:0], mosi1};
         rises1++;
         if (rises1 == 8) cur_addr1 = cap1[7:1];
         byte1 = mem[cur_addr1];
         if (rises1 >= 8 && rises1 < 16) miso1 = byte1[3'(15 - rises1)];
         else                            miso1 = 1'b0;
      end
   end

   // Device behind DUT2 always answers RESP2.
   logic [15:0] cap2 = '0;
   int          rises2 = 0, bad_per2 = 0;
   time         last_rise2 = 0;
   logic [7:0]  byte2;
   logic        cs2_q = 1'b1;
   always @(posedge sclk2 or cs2) begin
      if (cs2 !== cs2_q) begin
         if (cs2 === 1'b0) begin
            rises2 = 0;
            cap2   = '0;
            miso2  = 1'b0;
         end
         cs2_q = cs2;
      end else if (sclk2 === 1'b1) begin
         if (rises2 > 0 && ($time - last_rise2) != 2*D2*TCLK) bad_per2++;
         last_rise2 = $time;
         cap2 = {cap2[14:0], mosi2};
         rises2++;
         byte2 = RESP2;
         if (rises2 >= 8 && rises2 < 16) miso2 = byte2[3'(15 - rises2)];
         else                            miso2 = 1'b0;
      end
   end

   task automatic run1(input logic rw, input logic [6:0] a, input logic [7:0] wd, input bit poke);
      logic [15:0] exp_frame;
      int n, d0;
      exp_frame = {a, rw, (rw ? 8'h00 : wd)};
      d0 = done_cnt1;
      @(negedge clk);
      bus1.req = 1'b1; bus1.rw = rw; bus1.addr = a; bus1.wdata = wd;
      @(posedge clk); #1;
      // Scramble the inputs: the frame must come from the latched copy.
      bus1.req = 1'b0; bus1.rw = ~rw; bus1.addr = 7'($urandom); bus1.wdata = 8'($urandom);
      check("busy_after_accept", 32'(bus1.busy), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (poke) bus1.req = (n == 50);
      end while (bus1.done !== 1'b1 && n < 40*D1);
      check("latency", n, 35*D1);
      check("busy_in_done", 32'(bus1.busy), 32'd0);
      check("cs_in_done", 32'(cs1), 32'd1);
      if (rw) last_rdata1 = ref_mem[a];
      else    ref_mem[a] = wd;
      check("rdata", 32'(bus1.rdata), 32'(last_rdata1));
      check("frame", 32'(cap1), 32'(exp_frame));
      check("sclk_rises", rises1, 16);
      @(negedge clk);
      check("done_one_cycle", 32'(bus1.done), 32'd0);
      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt1 - d0, 1);
      check("sclk_period", bad_per1, 0);
      check("stray_sclk", stray1, 0);
   endtask

   task automatic run_held();
      int n, first, second, cs_hi, d0;
      d0 = done_cnt1; first = -1; second = -1; cs_hi = 0; n = 0;
      @(negedge clk);
      bus1.req = 1'b1; bus1.rw = 1'b0; bus1.addr = 7'h44; bus1.wdata = 8'h5A;
      @(posedge clk); #1;
      while (second < 0 && n < 80*D1) begin
         @(negedge clk);
         n++;
         if (bus1.done === 1'b1) begin
            if (first < 0) first = n;
            else           second = n;
         end
         if (cs1 === 1'b1 && (first < 0 || n < first + 20)) cs_hi++;
         if (first >= 0 && n == first + 3) bus1.req = 1'b0;
      end
      bus1.req = 1'b0;
      ref_mem[7'h44] = 8'h5A;
      check("held_first_latency", first, 35*D1);
      check("held_done_spacing", second - first, 35*D1 + 1);
      check("held_cs_gap_ok", 32'(cs_hi >= D1 + 1), 32'd1);
      check("held_frame", 32'(cap1), 32'h885A);
      repeat (3) @(negedge clk);
      check("held_done_pulses", done_cnt1 - d0, 2);
      check("held_rdata", 32'(bus1.rdata), 32'(last_rdata1));
   endtask

   task automatic run_reset_abort();
      int n, d0;
      d0 = done_cnt1;
      @(negedge clk);
      bus1.req = 1'b1; bus1.rw = 1'b1; bus1.addr = 7'h03; bus1.wdata = 8'h00;
      @(posedge clk); #1;
      bus1.req = 1'b0;
      for (n = 1; n < 70; n++) @(negedge clk);
      reset_n = 1'b0;
      #1;
      last_rdata1 = 8'h00;
      last_rdata2 = 8'h00;
      check("rst_mid_cs", 32'(cs1), 32'd1);
      check("rst_mid_sclk", 32'(sclk1), 32'd0);
      check("rst_mid_busy", 32'(bus1.busy), 32'd0);
      check("rst_mid_rdata", 32'(bus1.rdata), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40*D1) @(negedge clk);
      check("rst_no_done", done_cnt1 - d0, 0);
      run1(1'b1, 7'h03, 8'h00, 1'b0);
   endtask

   task automatic run2(input logic rw, input logic [6:0] a, input logic [7:0] wd);
      int n;
      @(negedge clk);
      bus2.req = 1'b1; bus2.rw = rw; bus2.addr = a; bus2.wdata = wd;
      @(posedge clk); #1;
      bus2.req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus2.done !== 1'b1 && n < 40*D2);
      if (rw) last_rdata2 = RESP2;
      check("d2_latency", n, 35*D2);
      check("d2_rdata", 32'(bus2.rdata), 32'(last_rdata2));
      check("d2_frame", 32'(cap2), 32'({a, rw, (rw ? 8'h00 : wd)}));
      check("d2_rises", rises2, 16);
      check("d2_period", bad_per2, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus1.req = 1'b0; bus1.rw = 1'b0; bus1.addr = '0; bus1.wdata = '0;
      bus2.req = 1'b0; bus2.rw = 1'b0; bus2.addr = '0; bus2.wdata = '0;
      for (int i = 0; i < 128; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[3]     = 8'h3C;
      ref_mem[3] = 8'h3C;

      repeat (3) @(negedge clk);
      check("rst_cs", 32'(cs1), 32'd1);
      check("rst_sclk", 32'(sclk1), 32'd0);
      check("rst_mosi", 32'(mosi1), 32'd0);
      check("rst_busy", 32'(bus1.busy), 32'd0);
      check("rst_done", 32'(bus1.done), 32'd0);
      check("rst_rdata", 32'(bus1.rdata), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run1(1'b0, 7'h15, 8'hA5, 1'b0);
      check("write_frame_2AA5", 32'(cap1), 32'h2AA5);
      run1(1'b1, 7'h03, 8'hFF, 1'b0);
      check("read_frame_0700", 32'(cap1), 32'h0700);
      check("read_rdata_3C", 32'(bus1.rdata), 32'h3C);
      run1(1'b0, 7'h22, 8'h81, 1'b1);
      run_held();
      for (int i = 0; i < 8; i++)
         run1(1'($urandom), 7'($urandom), 8'($urandom), 1'($urandom));
      run1(1'b1, 7'h15, 8'h00, 1'b0);
      run1(1'b1, 7'h44, 8'h00, 1'b0);
      run_reset_abort();

      run2(1'b0, 7'h55, 8'h3E);
      run2(1'b1, 7'h2A, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the sclk half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  transaction request, sampled only when busy=0.
REQ-005 rw  input  1  1=read, 0=write; latched with req.
REQ-006 addr  input  7  target memory address; latched with req.
REQ-007 wdata  input  8  write data; latched with req.
REQ-008 busy  output  1  high from the cycle after acceptance until the done cycle.
REQ-009 done  output  1  one-cycle pulse marking transaction completion.
REQ-010 rdata  output  8  read result; valid from the done pulse until the next read's done pulse.
REQ-011 cs_pin  output  1  SPI chip select, active-low.
REQ-012 sclk_pin  output  1  SPI clock, idle low.
REQ-013 mosi_pin  output  1  serial data to the memory.
REQ-014 miso_pin  input  1  serial data from the memory.

Function
REQ-015 States SHALL be IDLE, SETUP, SHIFT, HOLD, GUARD.
REQ-016 IDLE: cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0; req=1 at an edge latches rw/addr/wdata, enters SETUP.
REQ-017 SETUP: cs_pin=0, sclk_pin=0, mosi_pin=frame bit 15, for CLK_DIV cycles, then SHIFT.
REQ-018 Frame SHALL be 16 bits, MSB first: {addr[6:0], rw, data[7:0]}; data = wdata for write, all zeros for read.
REQ-019 SHIFT: each of 16 bits is CLK_DIV cycles sclk low then CLK_DIV cycles sclk high.
REQ-020 mosi_pin SHALL change only while sclk_pin is low, at the start of each bit's low phase.
REQ-021 On a read, miso_pin SHALL be sampled on the clk edge at which sclk_pin rises, for bits 7..0, shifted MSB first into a holding register.
REQ-022 After bit 0's high phase: HOLD, with sclk_pin=0 and cs_pin=0, for CLK_DIV cycles.
REQ-023 GUARD: cs_pin=1, sclk_pin=0, for CLK_DIV cycles.
REQ-024 At GUARD exit: done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
REQ-025 On a read, rdata SHALL update from the holding register in the done cycle; on a write, rdata SHALL hold its value.
REQ-026 Latency: acceptance edge T -> done high in cycle T+35*CLK_DIV (140 cycles at CLK_DIV=4).
REQ-027 req while busy=1 SHALL be ignored and not queued; latched fields SHALL not change mid-transaction.
REQ-028 req high in the done cycle SHALL not be accepted.
REQ-029 req held high in IDLE after done SHALL be accepted on the next edge, which guarantees cs_pin high for >= CLK_DIV+1 cycles between frames.
REQ-030 The half-period counter and the bit counter (0..15) SHALL wrap cleanly; no extra sclk edge SHALL appear at frame start or end.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=8'h00, with all counters cleared.
REQ-032 Reset mid-frame SHALL abort the frame without a done pulse; the first req after reset_n rises SHALL start a fresh SETUP.

Structure
REQ-033 The shared package SHALL hold the state encoding (IDLE=0..GUARD=4, 3 bits), FRAME_BITS=16, ADDR_W=7, DATA_W=8, and the RW_READ=1 constant.
REQ-034 One sub-module, spi_clk_gen, SHALL contain the CLK_DIV half-period counter and issue the sclk_pin level plus one-cycle rise/fall strobes.

Verification
REQ-035 Write: addr=7'h15, wdata=8'hA5, rw=0 -> mosi_pin captured on 16 sclk rises = 16'h2AA5; done at +140 cycles; rdata unchanged.
REQ-036 Read: addr=7'h03, rw=1, memory model drives 8'h3C -> mosi_pin captures 16'h0700; rdata=8'h3C at done.
REQ-037 req pulsed again at cycle +50 of a transaction -> ignored; exactly one done pulse; exactly 16 sclk rises.
REQ-038 req held high through two frames -> cs_pin high for >= 5 cycles between frames; two done pulses 141 cycles apart.
REQ-039 reset_n low at cycle +70 -> same cycle: cs_pin=1, sclk_pin=0, busy=0; no done pulse; next read completes correctly.
REQ-040 CLK_DIV=2 build -> sclk_pin period 4 cycles; done at +70 cycles.
